pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives PC write enable plus per-register hold and bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazard sources:
  - load-use data hazards (ID vs EX);
  - taken branches resolved in ID;
  - multi-cycle data-memory accesses in MEM, sequenced by an internal wait FSM.
- Hold means the register keeps its value. Bubble means the register loads all-zero.

Parameters:
- REG_ADDR_W, 5, register-index width.
- MEM_LAT, 4, data-memory access latency in cycles (≥1). 1 means single-cycle memory with no freeze.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- id_rs1_i  in  REG_ADDR_W  source reg 1 of the instruction in ID.
- id_rs2_i  in  REG_ADDR_W  source reg 2 of the instruction in ID.
- ex_rd_i  in  REG_ADDR_W  destination reg of the instruction in EX.
- ex_memread_i  in  1  instruction in EX is a load.
- id_branch_taken_i  in  1  branch in ID resolved taken this cycle.
- mem_req_i  in  1  instruction in MEM accesses data memory.
- pc_write_o  out  1  PC update enable.
- ifid_hold_o, ifid_bubble_o  out  1 each  IF/ID controls.
- idex_hold_o, idex_bubble_o  out  1 each  ID/EX controls.
- exmem_hold_o  out  1  EX/MEM hold.
- memwb_bubble_o  out  1  MEM/WB bubble.
- busy_o  out  1  memory freeze active this cycle.
- stall_cycles_o  out  32  perf counter (see Optional Feature).
- flush_count_o  out  32  perf counter (see Optional Feature).

Behaviour:
- State: FSM {RUN, WAIT} plus down-counter cnt, width clog2(MEM_LAT)+1.
- Reset: state=RUN, cnt=0, counters=0. While rst_i=1, outputs are forced:
  - pc_write_o=0;
  - all *_hold_o=0;
  - ifid_bubble_o=idex_bubble_o=memwb_bubble_o=1;
  - busy_o=0.
- Reset mid-WAIT abandons the access. After release the controller is in RUN with no residual freeze.
- freeze (combinational) = (state==RUN & mem_req_i & MEM_LAT>1) | (state==WAIT & cnt!=0).
- Transitions:
  - RUN → WAIT when mem_req_i & MEM_LAT>1; load cnt=MEM_LAT-2.
  - WAIT with cnt!=0: cnt-=1.
  - WAIT with cnt==0: → RUN. mem_req_i is ignored this cycle; it is the completing access.
  - Net result: exactly MEM_LAT-1 frozen cycles per access. Back-to-back accesses re-enter WAIT from RUN on the next cycle.
- loaduse = ex_memread_i & ex_rd_i!=0 & (ex_rd_i==id_rs1_i | ex_rd_i==id_rs2_i).
- Output priority (combinational, same cycle as inputs), highest first:
  1. freeze: pc_write_o=0, ifid_hold_o=idex_hold_o=exmem_hold_o=1, memwb_bubble_o=1, busy_o=1. loaduse and branch are suppressed and re-evaluate once the freeze ends.
  2. loaduse: pc_write_o=0, ifid_hold_o=1, idex_bubble_o=1. A taken branch in the same cycle is ignored; it re-resolves next cycle with the forwarded operand.
  3. id_branch_taken_i: ifid_bubble_o=1, pc_write_o=1.
  4. Otherwise: pc_write_o=1, all holds and bubbles 0.
- Hold and bubble are never both 1 for the same register.
- Latency: hazard controls are combinational. Only the WAIT state/cnt is registered.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cycles_o increments each cycle (rst_i=0) where pc_write_o==0;
  - flush_count_o increments each cycle where ifid_bubble_o==1 due to branch (priority 3);
  - both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports stay present and are tied to 0, and no counter flops are built.

Test Plan:
- Reset: rst_i=1 mid-WAIT with mem_req_i=1 → outputs take forced reset values. After release with mem_req_i=0 → pc_write_o=1, busy_o=0, state RUN.
- Load-use: ex_memread_i=1, ex_rd_i=5, id_rs2_i=5 for one cycle → pc_write_o=0, ifid_hold_o=1, idex_bubble_o=1. Repeat with ex_rd_i=0 → no stall.
- Branch: id_branch_taken_i=1, no loaduse → ifid_bubble_o=1, pc_write_o=1, flush_count_o +1 (HAZARD_PERF_EN). Same cycle with loaduse → loaduse response only.
- Memory freeze, MEM_LAT=4: mem_req_i held high 4 cycles → busy_o=1 for exactly 3 cycles, released on the 4th. A fresh mem_req_i on the 5th cycle → busy_o=1 again for 3 cycles.
- MEM_LAT=1: mem_req_i=1 continuously → busy_o never asserts.
- Freeze priority: mem_req_i=1 in RUN with loaduse and branch both asserted → only the freeze response, idex_bubble_o=0, ifid_bubble_o=0. stall_cycles_o counts all 3 frozen cycles (MEM_LAT=4).

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the 5-stage pipeline (load-use, taken branch, multi-cycle MEM freeze).
// Optional perf counters built only when HAZARD_PERF_EN is defined; otherwise the counter ports read 0.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MEM_LAT    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_memread_i,
  input  logic                  id_branch_taken_i,
  input  logic                  mem_req_i,
  output logic                  pc_write_o,
  output logic                  ifid_hold_o,
  output logic                  ifid_bubble_o,
  output logic                  idex_hold_o,
  output logic                  idex_bubble_o,
  output logic                  exmem_hold_o,
  output logic                  memwb_bubble_o,
  output logic                  busy_o,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           flush_count_o
);
  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam bit MULTI = (MEM_LAT > 1);
  localparam logic [CW-1:0] LOAD = CW'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);
  typedef enum logic {RUN, WAIT} state_t;
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic w_freeze, w_loaduse;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  // The cycle that leaves WAIT is the completing access, so mem_req_i is not sampled there.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (r_state == RUN) begin
      if (mem_req_i && MULTI) begin
        w_state_nx = WAIT;
        w_cnt_nx   = LOAD;
      end
    end else if (r_cnt != '0)
      w_cnt_nx = r_cnt - CW'(1);
    else
      w_state_nx = RUN;
  end
  assign w_freeze  = (r_state == RUN && mem_req_i && MULTI) || (r_state == WAIT && r_cnt != '0);
  assign w_loaduse = ex_memread_i && ex_rd_i != '0 && (ex_rd_i == id_rs1_i || ex_rd_i == id_rs2_i);
  assign pc_write_o     = !rst_i && !w_freeze && !w_loaduse;
  assign ifid_hold_o    = !rst_i && (w_freeze || w_loaduse);
  assign ifid_bubble_o  = rst_i || (!w_freeze && !w_loaduse && id_branch_taken_i);
  assign idex_hold_o    = !rst_i && w_freeze;
  assign idex_bubble_o  = rst_i || (!w_freeze && w_loaduse);
  assign exmem_hold_o   = !rst_i && w_freeze;
  assign memwb_bubble_o = rst_i || w_freeze;
  assign busy_o         = !rst_i && w_freeze;
`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall, r_flush;
  logic w_flush;
  assign w_flush = !w_freeze && !w_loaduse && id_branch_taken_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (!pc_write_o && r_stall != '1) r_stall <= r_stall + 32'd1;
      if (w_flush && r_flush != '1) r_flush <= r_flush + 32'd1;
    end
  assign stall_cycles_o = r_stall;
  assign flush_count_o  = r_flush;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for MEM_LAT=4 and MEM_LAT=1 instances sharing one stimulus stream.
module tb_pipeline_hazard_ctrl;
  logic clk = 0;
  logic rst = 1;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic mr = 0, br = 0, req = 0;
  logic [7:0] o4, o1;
  logic [31:0] s4, f4, s1, f1;
  int errors = 0, checks = 0;
  int pos4 = 0, pos1 = 0;
  logic [31:0] ms4 = 0, mf4 = 0, ms1 = 0, mf1 = 0;

  typedef struct {
    logic [7:0] o4; logic [31:0] s4, f4;
    logic [7:0] o1; logic [31:0] s1, f1;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut4 (
    .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2), .ex_rd_i(rd),
    .ex_memread_i(mr), .id_branch_taken_i(br), .mem_req_i(req),
    .pc_write_o(o4[7]), .ifid_hold_o(o4[6]), .ifid_bubble_o(o4[5]), .idex_hold_o(o4[4]),
    .idex_bubble_o(o4[3]), .exmem_hold_o(o4[2]), .memwb_bubble_o(o4[1]), .busy_o(o4[0]),
    .stall_cycles_o(s4), .flush_count_o(f4));

  pipeline_hazard_ctrl #(.MEM_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2), .ex_rd_i(rd),
    .ex_memread_i(mr), .id_branch_taken_i(br), .mem_req_i(req),
    .pc_write_o(o1[7]), .ifid_hold_o(o1[6]), .ifid_bubble_o(o1[5]), .idex_hold_o(o1[4]),
    .idex_bubble_o(o1[3]), .exmem_hold_o(o1[2]), .memwb_bubble_o(o1[1]), .busy_o(o1[0]),
    .stall_cycles_o(s1), .flush_count_o(f1));

  // Output order: {pc_write, ifid_hold, ifid_bubble, idex_hold, idex_bubble, exmem_hold, memwb_bubble, busy}
  function automatic logic [7:0] outs(bit r, bit frz, bit lu, bit b);
    if (r)   return 8'b0010_1010;
    if (frz) return 8'b0101_0111;
    if (lu)  return 8'b0100_1000;
    if (b)   return 8'b1010_0000;
    return 8'b1000_0000;
  endfunction

  // pos = position within a memory access: 0 idle, 1..lat-1 frozen, lat completing.
  task automatic model(input int lat, inout int pos, inout logic [31:0] sc, inout logic [31:0] fc,
                       input bit lu, output logic [7:0] o, output logic [31:0] so, output logic [31:0] fo);
    int cur;
    bit frz;
    if (rst) begin
      pos = 0; sc = 0; fc = 0;
    end
    cur = (!rst && pos == 0 && req && lat > 1) ? 1 : pos;
    frz = cur >= 1 && cur <= lat - 1;
    o = outs(rst, frz, lu, br);
`ifdef HAZARD_PERF_EN
    so = sc; fo = fc;
`else
    so = 0; fo = 0;
`endif
    if (!rst) begin
      if (!o[7] && sc != 32'hFFFF_FFFF) sc = sc + 1;
      if (!frz && !lu && br && fc != 32'hFFFF_FFFF) fc = fc + 1;
    end
    pos = (cur == 0 || cur == lat) ? 0 : cur + 1;
  endtask

  task automatic drive(bit r, int a1, int a2, int d, bit m, bit b, bit mq);
    exp_t e;
    bit lu;
    @(posedge clk);
    #1;
    rst = r; rs1 = 5'(a1); rs2 = 5'(a2); rd = 5'(d); mr = m; br = b; req = mq;
    lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
    model(4, pos4, ms4, mf4, lu, e.o4, e.s4, e.f4);
    model(1, pos1, ms1, mf1, lu, e.o1, e.s1, e.f1);
    q.push_back(e);
  endtask

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_lat4", {24'd0, o4}, {24'd0, e.o4});
      chk("stall_lat4", s4, e.s4);
      chk("flush_lat4", f4, e.f4);
      chk("out_lat1", {24'd0, o1}, {24'd0, e.o1});
      chk("stall_lat1", s1, e.s1);
      chk("flush_lat1", f1, e.f1);
    end
  end

  initial begin
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 5, 5, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 1, 2, 3, 0, 1, 0);
    drive(0, 5, 2, 5, 1, 1, 0);
    repeat (4) drive(0, 0, 0, 0, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (4) drive(0, 7, 1, 7, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(63) == 0, $urandom_range(3), $urandom_range(3), $urandom_range(3),
            $urandom_range(1) == 1, $urandom_range(2) == 0, $urandom_range(4) == 0);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0 pending", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
